// File: rtl/capture_upsizer_deadlock_pkg.sv
// Shared types and helpers for the capture_upsizer deadlock report path.
//   state_t          : report FSM states
//   INFO_FIELD_W     : bits of monitor info per AXIS channel
//   field_blocked()  : collapse one info field to a per-channel blocked bit
package capture_upsizer_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WATCH  = 2'd1,
    ST_REPORT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int unsigned INFO_FIELD_W = 2;

  // A channel counts as blocked when any bit of its info field is set.
  function automatic logic field_blocked(input logic [INFO_FIELD_W-1:0] field);
    return |field;
  endfunction

endpackage

// File: rtl/capture_upsizer_deadlock_timer.sv
// Saturating consecutive-cycle counter for stall persistence.
// Ports:
//   clock, reset      : clock, async active-low reset
//   inc               : count this cycle (takes priority below clr)
//   clr               : return the count to zero
//   threshold         : persistence threshold; 0 behaves as 1
//   count_next_c      : count value this cycle would produce if incremented
//   hit_c             : incremented count has reached the effective threshold
module capture_upsizer_deadlock_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] count_next_c,
  output logic             hit_c
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] thr_eff;

  // Saturate at all-ones rather than wrapping back to zero.
  assign count_next_c = (&count) ? count : count + CNT_W'(1);
  assign thr_eff      = (threshold == '0) ? CNT_W'(1) : threshold;
  // >= so a threshold lowered below the running count fires on the next blocked cycle.
  assign hit_c        = (count_next_c >= thr_eff);

  // Persistence counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count_next_c;
    end
  end

endmodule

// File: rtl/capture_upsizer_deadlock_report.sv
// Qualifies a persistent AXIS stall as a deadlock and hands a one-shot
// report to the debug/status register block over valid/ready.
// Optional feature: CAPTURE_UPSIZER_DEADLOCK_STAMP_EN adds a free-running
// cycle stamp latched into rpt_stamp at detection.
// Ports:
//   clock, reset      : clock, async active-low reset
//   block             : monitor's registered any-channel-blocked flag
//   axis_block_info   : 2 bits of info per channel
//   threshold         : consecutive blocked cycles to declare deadlock (0 -> 1)
//   clear             : synchronous clear of sticky flag and pending report
//   rpt_valid/ready   : report handshake
//   rpt_info          : info snapshot at detection
//   rpt_chan_mask     : per-channel blocked bits of the snapshot
//   rpt_count         : persistence count at detection
//   rpt_stamp         : cycle stamp at detection (stamp build only)
//   deadlock          : sticky deadlock-seen flag
module capture_upsizer_deadlock_report
  import capture_upsizer_deadlock_pkg::*;
#(
  parameter int unsigned NUM_CHAN = 2,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned STAMP_W  = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           block,
  input  logic [INFO_FIELD_W*NUM_CHAN-1:0] axis_block_info,
  input  logic [CNT_W-1:0]               threshold,
  input  logic                           clear,
  output logic                           rpt_valid,
  input  logic                           rpt_ready,
  output logic [INFO_FIELD_W*NUM_CHAN-1:0] rpt_info,
  output logic [NUM_CHAN-1:0]            rpt_chan_mask,
  output logic [CNT_W-1:0]               rpt_count,
`ifdef CAPTURE_UPSIZER_DEADLOCK_STAMP_EN
  output logic [STAMP_W-1:0]             rpt_stamp,
`endif
  output logic                           deadlock
);

  localparam int unsigned INFO_W = INFO_FIELD_W * NUM_CHAN;

  if (NUM_CHAN < 1 || CNT_W < 1 || STAMP_W < 1) begin : g_param_check
    $error("capture_upsizer_deadlock_report: NUM_CHAN, CNT_W and STAMP_W must be >= 1");
  end

  state_t              state;
  logic                watching_c;
  logic                cnt_inc_c;
  logic                cnt_clr_c;
  logic [CNT_W-1:0]    count_next_c;
  logic                hit_c;
  logic [NUM_CHAN-1:0] mask_c;

  // Counting only happens while looking for a stall; any other situation zeroes it.
  assign watching_c = (state == ST_IDLE) || (state == ST_WATCH);
  assign cnt_inc_c  = watching_c && block && !clear;
  assign cnt_clr_c  = !cnt_inc_c;

  capture_upsizer_deadlock_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock        (clock),
    .reset        (reset),
    .inc          (cnt_inc_c),
    .clr          (cnt_clr_c),
    .threshold    (threshold),
    .count_next_c (count_next_c),
    .hit_c        (hit_c)
  );

  // Per-channel blocked mask of the live info
  for (genvar k = 0; k < NUM_CHAN; k++) begin : g_mask
    assign mask_c[k] = field_blocked(axis_block_info[k*INFO_FIELD_W +: INFO_FIELD_W]);
  end

`ifdef CAPTURE_UPSIZER_DEADLOCK_STAMP_EN
  logic [STAMP_W-1:0] stamp;

  // Free-running cycle stamp, wraps naturally
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stamp <= '0;
    end else begin
      stamp <= stamp + STAMP_W'(1);
    end
  end
`endif

  // Report FSM and report registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      rpt_valid     <= 1'b0;
      rpt_info      <= '0;
      rpt_chan_mask <= '0;
      rpt_count     <= '0;
`ifdef CAPTURE_UPSIZER_DEADLOCK_STAMP_EN
      rpt_stamp     <= '0;
`endif
      deadlock      <= 1'b0;
    end else if (clear) begin
      // Clear wins over everything, including a same-cycle acceptance.
      state     <= ST_IDLE;
      rpt_valid <= 1'b0;
      deadlock  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_WATCH: begin
          if (!block) begin
            state <= ST_IDLE;
          end else if (hit_c) begin
            state         <= ST_REPORT;
            rpt_valid     <= 1'b1;
            deadlock      <= 1'b1;
            rpt_info      <= INFO_W'(axis_block_info);
            rpt_chan_mask <= mask_c;
            rpt_count     <= count_next_c;
`ifdef CAPTURE_UPSIZER_DEADLOCK_STAMP_EN
            rpt_stamp     <= stamp;
`endif
          end else begin
            state <= ST_WATCH;
          end
        end
        ST_REPORT: begin
          if (rpt_ready) begin
            state     <= ST_HOLD;
            rpt_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          // One report per stall episode: wait for the stall to end.
          if (!block) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/capture_upsizer_deadlock_report.md
# capture_upsizer_deadlock_report

Consumer side of the capture_upsizer AXIS deadlock monitor. It takes the monitor's registered `block` flag and the per-channel `axis_block_info` fields, and qualifies a stall as a deadlock only after it persists for a programmable number of consecutive cycles. On a deadlock it latches a one-shot report and presents it on a valid/ready interface toward the debug/status register block. It also holds a sticky `deadlock` flag until software clears it.

## Interface
Parameters:
- `NUM_CHAN`, 2: monitored AXIS channels; 2 bits of info per channel.
- `CNT_W`, 16: width of the persistence counter and threshold.
- `STAMP_W`, 32: width of the report timestamp (used only with the config macro).

Ports:
- `clock`  in  1  sole clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0). Already decided.
- `block`  in  1  monitor's registered any-channel-blocked flag.
- `axis_block_info`  in  2*NUM_CHAN  monitor info; field k = bits [2k+1:2k]; nonzero means channel k is blocked.
- `threshold`  in  CNT_W  consecutive blocked cycles needed to declare a deadlock; 0 is treated as 1.
- `clear`  in  1  synchronous single-cycle clear of the sticky flag and any pending report.
- `rpt_valid`  out  1  report available.
- `rpt_ready`  in  1  sink accepts the report.
- `rpt_info`  out  2*NUM_CHAN  info snapshot taken at detection.
- `rpt_chan_mask`  out  NUM_CHAN  bit k = OR-reduction of info field k in the snapshot.
- `rpt_count`  out  CNT_W  persistence count at detection (equals the effective threshold).
- `rpt_stamp`  out  STAMP_W  cycle stamp at detection. Present only with the config macro.
- `deadlock`  out  1  sticky deadlock-seen flag.

## Operation
- FSM states: IDLE, WATCH, REPORT, HOLD.
- IDLE:
  - Counter = 0.
  - `block`=1 → WATCH, counter = 1.
  - If the effective threshold is 1, IDLE goes directly to REPORT on that edge.
- WATCH:
  - `block`=1 → counter +1. The counter saturates at all-ones and never wraps.
  - `block`=0 → IDLE, counter = 0. No report, `deadlock` unchanged.
- Detection:
  - Occurs on the edge where the incremented count equals the effective threshold.
  - Latch `axis_block_info` from that cycle, its chan mask, the count, and the stamp.
  - Set `deadlock`; go to REPORT.
- REPORT:
  - `rpt_valid`=1; all `rpt_*` outputs are held stable until `rpt_ready`=1 on a rising edge.
  - Acceptance → HOLD. `rpt_valid` is not combinationally dependent on `rpt_ready`.
  - `block` changes during REPORT are ignored.
- HOLD:
  - Waits for `block`=0, then → IDLE. This gives one report per stall episode.
  - `deadlock` stays 1.
- `clear`:
  - Highest priority in any state: → IDLE, counter 0, `deadlock` 0, `rpt_valid` 0.
  - An unaccepted report is discarded.
  - Clear with simultaneous `rpt_ready` does not count as an acceptance.
- A threshold change mid-WATCH takes effect on the next compare.
  - If the count has already passed the new threshold, detection fires on the next blocked cycle.
- `rpt_*` outputs retain their last latched values outside REPORT.

## Timing
- Reset (`reset`=0) values: FSM IDLE, counter 0, `rpt_valid` 0, `rpt_info` 0, `rpt_chan_mask` 0, `rpt_count` 0, `rpt_stamp` 0, `deadlock` 0, stamp counter 0.
- Reset mid-report drops `rpt_valid` asynchronously.
- Latency: if `block`=1 at edges t..t+T-1, `rpt_valid` and `deadlock` are 1 after edge t+T-1, i.e. T cycles after the first blocked sample.
- Handshake: transfer on an edge with `rpt_valid`=1 and `rpt_ready`=1. `rpt_valid` falls after that edge.
- All outputs are registered.

## Configuration
- `CAPTURE_UPSIZER_DEADLOCK_STAMP_EN` defined:
  - A STAMP_W free-running cycle counter runs from reset and wraps modulo 2^STAMP_W.
  - Its value at the detection edge is latched into `rpt_stamp`.
- Undefined: no stamp counter and no `rpt_stamp` port. All other behaviour is identical.

## Structure
- Package `capture_upsizer_deadlock_pkg` holds:
  - FSM state enum.
  - `INFO_FIELD_W`=2.
  - Field-to-mask decode function.
- Sub-module `capture_upsizer_deadlock_timer`: saturating consecutive-cycle counter with increment, clear and threshold-hit output. The top-level block holds the FSM, report registers and stamp.

## Test plan
- Threshold 4, `block`=1 for 4 cycles with info 4'b0010 → `rpt_valid` after the 4th edge; `rpt_info`=4'b0010, `rpt_chan_mask`=2'b01, `rpt_count`=4, `deadlock`=1.
- Threshold 4, `block` high 3 cycles then low → no `rpt_valid`, `deadlock`=0, counter back to 0.
- Detection with `rpt_ready`=0 for 10 cycles while info changes → outputs stable. `rpt_ready`=1 → `rpt_valid` falls next edge. With `block` still 1 there is no second report; `block` 0 then a new 4-cycle stall gives a second report.
- `clear` asserted while `rpt_valid`=1 and `rpt_ready`=1 → `rpt_valid`=0, `deadlock`=0, FSM IDLE.
- Threshold 0 with a single-cycle `block` and info 4'b0101 → report with `rpt_count`=1 and `rpt_chan_mask`=2'b11.
- `reset` asserted mid-WATCH and mid-REPORT → all outputs 0 immediately. With the macro defined, the stamp restarts from 0 and `rpt_stamp` equals the detection cycle index.
